// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared defaults and round/saturate helpers for the FIR
//               decimator output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int C_WIDTH_IN  = 17;
    localparam int C_WIDTH_OUT = 8;
    localparam int C_SHIFT     = 3;
    localparam int C_R         = 2;
    localparam int C_DEPTH     = 4;

    // Add half an LSB, then floor-shift: rounds half toward +inf.
    function automatic logic signed [63:0] fp_round_shift(
        input logic signed [63:0] x,
        input int                 shift
    );
        logic signed [63:0] bias;
        if (shift == 0) begin
            return x;
        end
        bias = 64'sd1 <<< (shift - 1);
        return (x + bias) >>> shift;
    endfunction

    function automatic logic signed [63:0] fp_clamp(
        input logic signed [63:0] x,
        input int                 wout
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wout - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head read and
//               simultaneous push/pop while full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd];
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    assign w_do_pop  = pop && !empty && !clr;
    assign w_do_push = push && (!full || w_do_pop) && !clr;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_decim_sat.sv
// ============================================================================
// Module      : fir_decim_sat
// Description : Decimates FIR output by R, rounds/shifts, saturates and
//               buffers the result in an output FIFO with sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_decim_sat
    import fir_pkg::*;
#(
    parameter int WIDTH_IN  = C_WIDTH_IN,
    parameter int WIDTH_OUT = C_WIDTH_OUT,
    parameter int SHIFT     = C_SHIFT,
    parameter int R         = C_R,
    parameter int DEPTH     = C_DEPTH
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr,
    input  logic                        in_en,
    input  logic signed [WIDTH_IN-1:0]  din,
    output logic signed [WIDTH_OUT-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat_flag,
    output logic                        ovf_flag
);

    localparam int             PW     = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0]  C_LAST = PW'(R - 1);
    localparam int             CW     = $clog2(DEPTH) + 1;

    logic [PW-1:0]                r_phase;
    logic                         r_pipe_vld;
    logic signed [WIDTH_OUT-1:0]  r_pipe_data;
    logic                         r_sat;
    logic                         r_ovf;

    logic signed [63:0]           w_x;
    logic signed [63:0]           w_shifted;
    logic signed [63:0]           w_clamped;
    logic                         w_sat;
    logic                         w_kept;
    logic                         w_full;
    logic                         w_empty;
    logic [CW-1:0]                w_count;
    logic [WIDTH_OUT-1:0]         w_dout;
    logic                         w_pop;
    logic                         w_push;

    assign w_x       = {{(64-WIDTH_IN){din[WIDTH_IN-1]}}, din};
    assign w_shifted = fp_round_shift(w_x, SHIFT);
    assign w_clamped = fp_clamp(w_shifted, WIDTH_OUT);
    assign w_sat     = (w_clamped != w_shifted);
    assign w_kept    = in_en && (r_phase == C_LAST);

    assign out_valid = (w_count != '0);
    assign out_data  = w_empty ? '0 : w_dout;
    assign sat_flag  = r_sat;
    assign ovf_flag  = r_ovf;

    assign w_pop     = out_valid && out_ready && !clr;
    assign w_push    = r_pipe_vld && !clr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase     <= '0;
            r_pipe_vld  <= 1'b0;
            r_pipe_data <= '0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            r_phase     <= '0;
            r_pipe_vld  <= 1'b0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (in_en) begin
                r_phase <= w_kept ? '0 : r_phase + PW'(1);
            end
            r_pipe_vld <= w_kept;
            if (w_kept) begin
                r_pipe_data <= w_clamped[WIDTH_OUT-1:0];
                if (w_sat) begin
                    r_sat <= 1'b1;
                end
            end
            // The staged word is lost only if nothing leaves the full FIFO.
            if (r_pipe_vld && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (w_push),
        .din   (r_pipe_data),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

endmodule

`default_nettype wire
